// File: rtl/llc_pipe_ctrl.sv
// llc_pipe_ctrl: in-order request pipeline controller for the last-level cache.
// Each stage holds {valid, set, payload}. Bubbles collapse: a stage moves
// whenever its successor is empty or draining. Admission can optionally be
// blocked while any in-flight request targets the same set. A flush clears
// every stage synchronously, and the async active-low reset clears all state.
module llc_pipe_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int SET_BITS   = 9,
    parameter int PAYLOAD_W  = 32,
    parameter int HAZARD_EN  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [SET_BITS-1:0]                in_set,
    input  logic [PAYLOAD_W-1:0]               in_payload,
    input  logic [NUM_STAGES-1:0]              stage_hold,
    output logic [NUM_STAGES-1:0]              stage_valid,
    output logic [NUM_STAGES*SET_BITS-1:0]     stage_set,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [SET_BITS-1:0]                out_set,
    output logic [PAYLOAD_W-1:0]               out_payload,
    output logic [$clog2(NUM_STAGES+1)-1:0]    occupancy,
    output logic [15:0]                        hazard_stalls
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] v_r;
    logic [SET_BITS-1:0]   set_r [NUM_STAGES];
    logic [PAYLOAD_W-1:0]  payload_r [NUM_STAGES];
    logic [OCC_W-1:0]      occ_r;
    logic [15:0]           stalls_r;

    logic [NUM_STAGES-1:0] adv_s;
    logic                  out_valid_s;
    logic                  hazard_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  retire_s;

    assign out_valid_s = v_r[NUM_STAGES-1] & ~stage_hold[NUM_STAGES-1];

    // Advance chain, resolved from the exit stage back to the entry stage.
    always_comb begin
        logic go_s;
        go_s = out_valid_s & out_ready;
        adv_s = '0;
        adv_s[NUM_STAGES-1] = go_s;
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            go_s = v_r[i] & ~stage_hold[i] & (~v_r[i+1] | go_s);
            adv_s[i] = go_s;
        end
    end

    // Same-set hazard against every occupied stage, using current registers.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (v_r[i] && (set_r[i] == in_set)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        if (HAZARD_EN == 0) begin
            hazard_s = 1'b0;
        end else begin
            hazard_s = hazard_s;
        end
    end

    assign in_ready_s = ~flush & ~hazard_s & (~v_r[0] | adv_s[0]);
    assign accept_s   = in_valid & in_ready_s;
    assign retire_s   = adv_s[NUM_STAGES-1];

    // Stage registers: load on accept, shift on advance, clear on drain/flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_r <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                set_r[i]     <= '0;
                payload_r[i] <= '0;
            end
        end else if (flush) begin
            v_r <= '0;
        end else begin
            for (int i = NUM_STAGES - 1; i >= 1; i--) begin
                if (adv_s[i-1]) begin
                    v_r[i]       <= 1'b1;
                    set_r[i]     <= set_r[i-1];
                    payload_r[i] <= payload_r[i-1];
                end else if (adv_s[i]) begin
                    v_r[i] <= 1'b0;
                end
            end
            if (accept_s) begin
                v_r[0]       <= 1'b1;
                set_r[0]     <= in_set;
                payload_r[0] <= in_payload;
            end else if (adv_s[0]) begin
                v_r[0] <= 1'b0;
            end
        end
    end

    // Occupancy tracks accepts minus retires; flush empties the pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_r <= '0;
        end else if (flush) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_r + OCC_W'(accept_s) - OCC_W'(retire_s);
        end
    end

    // Saturating count of cycles where a valid request was held off by a hazard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stalls_r <= 16'd0;
        end else if (in_valid && hazard_s && !flush && (stalls_r != 16'hFFFF)) begin
            stalls_r <= stalls_r + 16'd1;
        end
    end

    // Flatten per-stage set indices onto the observation bus.
    always_comb begin
        stage_set = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_set[i*SET_BITS +: SET_BITS] = set_r[i];
        end
    end

    assign in_ready      = in_ready_s;
    assign stage_valid   = v_r;
    assign out_valid     = out_valid_s;
    assign out_set       = set_r[NUM_STAGES-1];
    assign out_payload   = payload_r[NUM_STAGES-1];
    assign occupancy     = occ_r;
    assign hazard_stalls = stalls_r;

endmodule
